qtree_result_buf: RTL
=====================

// Module: qtree_result_buf
//
// PURPOSE
// Output buffer placed directly downstream of the quadtree lookup pipeline.
// The pipeline produces one result per valid cycle and cannot be stalled. This block
// captures each result (match, bypass, addr, key) into a FIFO and offers the results
// to the consumer over a valid/ready interface.
// almost_full_o is the early throttle for the lookup source. Results that arrive
// while the FIFO is full are dropped and counted.
//
// PARAMETERS
// KEY_WIDTH     16  lookup key width; equals the pipeline KEY_WIDTH
// BYPASS_WIDTH   1  user sideband width, carried unchanged
// ADDR_WIDTH    14  matched-entry address width ((STAGES+1)*2+$clog2(D_CNT))
// DEPTH          8  FIFO entries; must be a power of 2, >= 2
// AFULL_SLACK    3  almost_full_o asserts when fill_o >= DEPTH-AFULL_SLACK
//
// PORTS
// clk_i            in   1                    clock
// rst_n_i          in   1                    async reset, active-low
// lookup_valid_i   in   1                    result valid from pipeline (no backpressure)
// lookup_match_i   in   1                    result hit flag
// lookup_bypass_i  in   BYPASS_WIDTH         sideband
// lookup_addr_i    in   ADDR_WIDTH           matched address
// lookup_data_i    in   KEY_WIDTH            original key
// res_valid_o      out  1                    head entry available
// res_ready_i      in   1                    consumer accepts head
// res_match_o      out  1                    head match
// res_bypass_o     out  BYPASS_WIDTH         head sideband
// res_addr_o       out  ADDR_WIDTH           head address
// res_data_o       out  KEY_WIDTH            head key
// fill_o           out  $clog2(DEPTH)+1      current occupancy
// almost_full_o    out  1                    throttle hint to lookup source
// overflow_o       out  1                    sticky: at least one result dropped
// drop_cnt_o       out  16                   dropped results, saturating
// clr_stats_i      in   1                    sync clear of overflow_o, drop_cnt_o (and stats)
//
// BEHAVIOUR
// - Reset (rst_n_i low, async): pointers, fill_o, res_valid_o, almost_full_o, overflow_o,
//   drop_cnt_o and all res_*_o data are cleared to 0. Contents in flight at reset are
//   discarded. The first push is allowed on the first clock edge after deassertion.
// - Push = lookup_valid_i and (not full, or pop in the same cycle).
// - Pop = res_valid_o and res_ready_i.
// - Latency: a result pushed at edge N is visible on res_*_o after edge N.
//   There is no combinational fall-through from lookup_*_i to res_*_o.
// - Ordering: strict FIFO. res_*_o holds the head stable while res_valid_o=1 and
//   res_ready_i=0. Data values are don't-care while res_valid_o=0 (except after reset: 0).
// - Full with push and pop in the same cycle: both occur, and fill_o is unchanged.
// - Empty with push and pop: pop is impossible (res_valid_o=0), so only the push occurs.
// - Full with push and no pop: the result is dropped. overflow_o is set (sticky), and
//   drop_cnt_o increments, saturating at 16'hFFFF.
// - clr_stats_i has priority over a same-cycle drop. The counter is written 0, not 1.
// - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fill_o is a registered
//   up/down counter, range 0..DEPTH.
// - almost_full_o = (fill_o >= DEPTH-AFULL_SLACK), decoded from registered fill_o.
//
// CONFIGURATION
// QTREE_RESULT_STATS_EN defined:
//   - adds outputs match_cnt_o[31:0] and miss_cnt_o[31:0].
//   - They count pushed (non-dropped) results by lookup_match_i. They wrap modulo 2^32.
//   - Both are reset to 0 and cleared by clr_stats_i.
// QTREE_RESULT_STATS_EN undefined: these ports and counters do not exist. All other
//   behaviour is identical.
//
// TESTING
// 1. Reset, then 3 pushes (addr 1,2,3) with ready=0 -> fill_o=3, head addr=1 held; set
//    ready=1 -> addr 1,2,3 popped in order, res_valid_o=0 after the 3rd pop.
// 2. DEPTH=8, AFULL_SLACK=3, ready=0, push 5 -> almost_full_o rises the cycle after the 5th push
//    and is low after 4 pushes.
// 3. Fill to 8, push 2 more with ready=0 -> both dropped, drop_cnt_o=2, overflow_o=1, head
//    unchanged; clr_stats_i -> both cleared.
// 4. Full, push and pop in the same cycle, repeated 20 cycles -> fill_o stays 8, no drops,
//    output order matches input order across pointer wrap.
// 5. rst_n_i pulsed low mid-stream (fill 5) -> res_valid_o and fill_o drop to 0 without
//    a clock; next push is visible 1 cycle later.
// 6. STATS_EN: 6 pushes with 4 hits and 2 misses, plus 1 dropped hit -> match_cnt_o=4,
//    miss_cnt_o=2.

Source files
------------

// File: rtl/qtree_result_buf.sv
// Result FIFO behind the quadtree lookup pipeline; drops and counts on full.
// Ports: lookup_*_i push side, res_*_o/res_ready_i pop side, fill/afull/overflow/drop stats.
// Optional QTREE_RESULT_STATS_EN adds match_cnt_o/miss_cnt_o hit/miss counters.
module qtree_result_buf #(
  parameter int KEY_WIDTH    = 16,
  parameter int BYPASS_WIDTH = 1,
  parameter int ADDR_WIDTH   = 14,
  parameter int DEPTH        = 8,
  parameter int AFULL_SLACK  = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    lookup_valid_i,
  input  logic                    lookup_match_i,
  input  logic [BYPASS_WIDTH-1:0] lookup_bypass_i,
  input  logic [ADDR_WIDTH-1:0]   lookup_addr_i,
  input  logic [KEY_WIDTH-1:0]    lookup_data_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic                    res_match_o,
  output logic [BYPASS_WIDTH-1:0] res_bypass_o,
  output logic [ADDR_WIDTH-1:0]   res_addr_o,
  output logic [KEY_WIDTH-1:0]    res_data_o,
  output logic [$clog2(DEPTH):0]  fill_o,
  output logic                    almost_full_o,
  output logic                    overflow_o,
  output logic [15:0]             drop_cnt_o,
  input  logic                    clr_stats_i
`ifdef QTREE_RESULT_STATS_EN
  ,output logic [31:0]            match_cnt_o
  ,output logic [31:0]            miss_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;
  localparam int EW = 1 + BYPASS_WIDTH + ADDR_WIDTH + KEY_WIDTH;
  localparam logic [FW-1:0] FULL_LVL  = FW'(DEPTH);
  localparam logic [FW-1:0] AFULL_LVL = FW'(DEPTH - AFULL_SLACK);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] head;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  assign full  = (fill_o == FULL_LVL);
  assign pop   = res_valid_o & res_ready_i;
  // A pop frees the slot the same cycle, so full+pop still accepts.
  assign push  = lookup_valid_i & (~full | pop);
  assign drop  = lookup_valid_i & ~push;

  assign res_valid_o   = (fill_o != '0);
  assign almost_full_o = (fill_o >= AFULL_LVL);

  // Storage needs no reset; outputs are masked while empty.
  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr] <= {lookup_match_i, lookup_bypass_i,
                      lookup_addr_i, lookup_data_i};
  end

  assign head = res_valid_o ? mem[rd_ptr] : '0;
  assign {res_match_o, res_bypass_o, res_addr_o, res_data_o} = head;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_o <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        fill_o <= fill_o + FW'(1);
      else if (pop && !push)
        fill_o <= fill_o - FW'(1);
    end
  end

  // Clear wins over a same-cycle drop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clr_stats_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != 16'hFFFF)
        drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

`ifdef QTREE_RESULT_STATS_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      match_cnt_o <= '0;
      miss_cnt_o  <= '0;
    end else if (clr_stats_i) begin
      match_cnt_o <= '0;
      miss_cnt_o  <= '0;
    end else if (push) begin
      if (lookup_match_i)
        match_cnt_o <= match_cnt_o + 32'd1;
      else
        miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`else
  // Hit/miss counters are absent in this build.
`endif

endmodule
